// File: rtl/rxtx_result_arbiter_pkg.sv
// Shared types and default sizing for the RxTx result arbiter and its channel FIFOs.
package rxtx_result_arbiter_pkg;

  typedef enum logic {MODE_SELECT = 1'b0, MODE_ROUND_ROBIN = 1'b1} result_mode_t;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_DRAIN = 1'b1} arb_state_t;

  localparam int RESULT_FIFO_WIDTH  = 32;
  localparam int TOTAL_RESULT_FIFOS = 8;
  localparam int RESULT_FIFO_DEPTH  = 16;
  localparam int RESULT_BURST       = 8;

endpackage

// File: rtl/rxtx_sync_fifo.sv
// Single-clock FIFO with an extra wrap bit on each pointer to tell full from empty.
module rxtx_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; a flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rxtx_result_arbiter.sv
// Buffers per-stage result streams in channel FIFOs and drains them in bursts onto one
// tagged tx word stream, either from a host-selected channel or round-robin.
module rxtx_result_arbiter
  import rxtx_result_arbiter_pkg::*;
#(
  parameter int WIDTH    = RESULT_FIFO_WIDTH,
  parameter int CHANNELS = TOTAL_RESULT_FIFOS,
  parameter int DEPTH    = RESULT_FIFO_DEPTH,
  parameter int BURST    = RESULT_BURST
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  mode,
  input  logic [$clog2(CHANNELS)-1:0]           sel,
  input  logic [CHANNELS-1:0]                   in_valid,
  input  logic [CHANNELS*WIDTH-1:0]             in_data,
  output logic [CHANNELS-1:0]                   in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH-1:0]                      out_data,
  output logic [$clog2(CHANNELS)-1:0]           out_chan,
  output logic                                  out_last,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0] level,
  output logic [CHANNELS-1:0]                   overflow,
  output logic                                  state
);

  localparam int CW  = $clog2(CHANNELS);
  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int BCW = $clog2(BURST + 1);
  localparam int CP  = 1 << CW;

  // Output handshake: a word transfers on a rising edge where out_valid & out_ready;
  // once raised, out_valid and the word stay put until that transfer happens.

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [WIDTH-1:0]    head [CHANNELS];
  logic [LW-1:0]       lvl  [CHANNELS];
  logic [CP-1:0]       avail;
  logic [CP-1:0]       push_pad;

  arb_state_t          state_q;
  logic [CW-1:0]       grant_q;
  logic [CW-1:0]       last_q;
  logic [BCW-1:0]      count_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [CW-1:0]       out_chan_q;
  logic                out_last_q;
  logic [CHANNELS-1:0] overflow_q;

  logic                rr_mode;
  logic                rr_found;
  logic [CW-1:0]       rr_pick;
  logic                grant_ok;
  logic [CW-1:0]       grant_pick;
  logic                load;
  logic                load_last;
  logic                accept;
  logic                last_accept;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_chan
      assign push[c] = in_valid[c] & ~full[c];
      assign pop[c]  = load & (grant_q == CW'(c));

      rxtx_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push[c]),
        .push_data (in_data[c*WIDTH +: WIDTH]),
        .pop       (pop[c]),
        .pop_data  (head[c]),
        .full      (full[c]),
        .empty     (empty[c]),
        .level     (lvl[c])
      );

      assign level[c*LW +: LW] = lvl[c];
    end
  endgenerate

  // Padding to a power of two makes an out-of-range sel read as an empty channel.
  assign avail    = CP'(~empty);
  assign push_pad = CP'(push);
  assign in_ready = ~full;

  assign rr_mode    = (mode == 1'(MODE_ROUND_ROBIN));
  assign grant_ok   = rr_mode ? rr_found : avail[sel];
  assign grant_pick = rr_mode ? rr_pick : sel;

  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!rr_found && avail[(int'(last_q) + i) % CHANNELS]) begin
        rr_found = 1'b1;
        rr_pick  = CW'((int'(last_q) + i) % CHANNELS);
      end
    end
  end

  assign accept      = out_valid_q & out_ready;
  assign last_accept = accept & out_last_q;

  // Stop fetching once the closing word of the grant sits in the output register.
  assign load = (state_q == ARB_DRAIN) && !(out_valid_q && out_last_q) &&
                (!out_valid_q || out_ready) && avail[grant_q];

  assign load_last = ((int'(count_q) + 1) == BURST) ||
                     ((lvl[grant_q] == LW'(1)) && !push_pad[grant_q]);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= CW'(CHANNELS - 1);
      count_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_ok) begin
            grant_q <= grant_pick;
            count_q <= '0;
            state_q <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (load) count_q <= count_q + 1'b1;
          if (last_accept) begin
            last_q  <= grant_q;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= head[grant_q];
      out_chan_q  <= grant_q;
      out_last_q  <= load_last;
    end else if (accept) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      overflow_q <= '0;
    end else begin
      overflow_q <= overflow_q | (in_valid & full);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign state     = state_q;

endmodule

// File: tb/tb_rxtx_result_arbiter.sv
// Randomised and directed bench for rxtx_result_arbiter with a queue-based reference model.
module tb_rxtx_result_arbiter;
  import rxtx_result_arbiter_pkg::*;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 8;
  localparam int DEPTH    = 16;
  localparam int BURST    = 8;
  localparam int CW       = 3;
  localparam int LW       = 5;
  localparam int EW       = WIDTH + CW + 1;

  logic                     clk;
  logic                     reset;
  logic                     clear;
  logic                     mode;
  logic [CW-1:0]            sel;
  logic [CHANNELS-1:0]      in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]      in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [CW-1:0]            out_chan;
  logic                     out_last;
  logic [CHANNELS*LW-1:0]   level;
  logic [CHANNELS-1:0]      overflow;
  logic                     state;

  rxtx_result_arbiter #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .BURST(BURST)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .level(level),
    .overflow(overflow), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel word queues, sticky overflow, round-robin memory.
  logic [WIDTH-1:0]    model_q [CHANNELS][$];
  logic [EW-1:0]       exp_q[$];
  logic [CHANNELS-1:0] ovf_m;
  int                  m_last;
  int                  ready_mode;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  logic          flush_at_edge = 1'b0;
  logic          hold_pending  = 1'b0;
  logic [EW-1:0] hold_word;
  logic [EW-1:0] act_word;
  logic [EW-1:0] exp_word;

  always @(posedge clk) flush_at_edge <= reset | clear;

  always @(negedge clk) begin
    act_word = {out_last, out_chan, out_data};
    if (hold_pending && !flush_at_edge) begin
      checks++;
      if (!out_valid || act_word != hold_word) begin
        errors++;
        $display("FAIL hold_stable: got valid=%0d word=0x%0h, expected valid=1 word=0x%0h",
                 out_valid, act_word, hold_word);
      end
    end
    hold_pending = out_valid && !out_ready;
    hold_word    = act_word;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got last=%0d chan=%0d data=0x%08h, expected no word",
                 out_last, out_chan, out_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (act_word != exp_word) begin
          errors++;
          $display("FAIL out_word: got last=%0d chan=%0d data=0x%08h, expected last=%0d chan=%0d data=0x%08h",
                   act_word[EW-1], act_word[EW-2:WIDTH], act_word[WIDTH-1:0],
                   exp_word[EW-1], exp_word[EW-2:WIDTH], exp_word[WIDTH-1:0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] lvl_of(input int c);
    return level[c*LW +: LW];
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) model_q[c].delete();
    exp_q.delete();
    ovf_m  = '0;
    m_last = CHANNELS - 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clear = 1'b0; in_valid = '0; in_data = '0;
    mode = 1'b0; sel = '0; ready_mode = 0;
    cycles(2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  // One grant: up to BURST words, the final one flagged last.
  task automatic model_burst(input int c);
    int n;
    logic [WIDTH-1:0] w;
    n = (model_q[c].size() < BURST) ? model_q[c].size() : BURST;
    for (int i = 0; i < n; i++) begin
      w = model_q[c].pop_front();
      exp_q.push_back({(i == n - 1), CW'(c), w});
    end
    if (n > 0) m_last = c;
  endtask

  task automatic model_drain_select(input int c);
    while (model_q[c].size() > 0) model_burst(c);
  endtask

  task automatic model_drain_rr();
    int found;
    while (1) begin
      found = -1;
      for (int i = 1; i <= CHANNELS; i++)
        if (found < 0 && model_q[(m_last + i) % CHANNELS].size() > 0) found = (m_last + i) % CHANNELS;
      if (found < 0) break;
      model_burst(found);
    end
  endtask

  task automatic model_push(input int c, input logic [WIDTH-1:0] d);
    if (model_q[c].size() < DEPTH) model_q[c].push_back(d);
    else ovf_m[c] = 1'b1;
  endtask

  task automatic push_words(input int c, input int n);
    logic [WIDTH-1:0] d;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("in_ready_push", in_ready[c], model_q[c].size() < DEPTH);
      d = $urandom;
      in_valid[c] = 1'b1;
      in_data[c*WIDTH +: WIDTH] = d;
      model_push(c, d);
    end
    @(negedge clk);
    in_valid[c] = 1'b0;
  endtask

  task automatic load_random(input int park, input int ncyc);
    logic [WIDTH-1:0] d;
    logic [CHANNELS-1:0] exp_rdy;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      for (int c = 0; c < CHANNELS; c++) exp_rdy[c] = (model_q[c].size() < DEPTH);
      check("in_ready_rand", in_ready, exp_rdy);
      for (int c = 0; c < CHANNELS; c++) begin
        in_valid[c] = (c != park) && ($urandom_range(0, 3) != 0);
        if (in_valid[c]) begin
          d = $urandom;
          in_data[c*WIDTH +: WIDTH] = d;
          model_push(c, d);
        end
      end
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic check_levels(input string name);
    for (int c = 0; c < CHANNELS; c++) check(name, lvl_of(c), model_q[c].size());
  endtask

  task automatic wait_out_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
    cycles(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; clear = 1'b0; mode = 1'b0; sel = '0;
    in_valid = '0; in_data = '0; ready_mode = 0;
    model_reset();
    do_reset();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_out_last", out_last, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_ready", in_ready, {CHANNELS{1'b1}});
    check("rst_state", state, 0);

    // Single word, select mode: two-cycle latency
    mode = 1'b0; sel = 3'd3; ready_mode = 1;
    cycles(2);
    @(negedge clk);
    in_valid[3] = 1'b1;
    in_data[3*WIDTH +: WIDTH] = 32'hA5A5_0001;
    model_push(3, 32'hA5A5_0001);
    model_drain_select(3);
    @(negedge clk);
    in_valid[3] = 1'b0;
    check("t1_valid_t0", out_valid, 0);
    @(negedge clk);
    check("t1_valid_t1", out_valid, 0);
    @(negedge clk);
    check("t1_valid_t2", out_valid, 1);
    check("t1_data", out_data, 32'hA5A5_0001);
    check("t1_chan", out_chan, 3);
    check("t1_last", out_last, 1);
    wait_drain(20);

    // Round-robin bursts across ch0 (10 words) and ch5 (2 words)
    do_reset();
    mode = 1'b0; sel = 3'd7;
    push_words(0, 10);
    push_words(5, 2);
    check_levels("t2_level_loaded");
    ready_mode = 1;
    mode = 1'b1;
    model_drain_rr();
    wait_drain(200);
    check_levels("t2_level_drained");

    // Overflow on a full channel, then a stalled drain of it
    mode = 1'b0; sel = 3'd0;
    push_words(1, DEPTH + 1);
    check("t3_in_ready", in_ready[1], 0);
    check("t3_overflow", overflow, ovf_m);
    check("t3_level", lvl_of(1), DEPTH);
    ready_mode = 0;
    cycles(1);
    model_drain_select(1);
    sel = 3'd1;
    wait_out_valid(20);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_stall_level", lvl_of(1), DEPTH - 1);
      check("t4_stall_valid", out_valid, 1);
    end
    ready_mode = 2;
    wait_drain(400);
    check("t3_overflow_sticky", overflow[1], 1);
    check_levels("t3_level_drained");

    // Clear during DRAIN with a simultaneous push
    sel = 3'd0;
    push_words(2, 4);
    ready_mode = 0;
    cycles(1);
    sel = 3'd2;
    wait_out_valid(20);
    check("t5_state_drain", state, 1);
    @(negedge clk);
    clear = 1'b1;
    in_valid[2] = 1'b1;
    in_data[2*WIDTH +: WIDTH] = $urandom;
    @(negedge clk);
    clear = 1'b0;
    in_valid[2] = 1'b0;
    model_reset();
    check("t5_out_valid", out_valid, 0);
    check("t5_level", level, 0);
    check("t5_overflow", overflow, 0);
    check("t5_state", state, 0);
    check("t5_in_ready", in_ready, {CHANNELS{1'b1}});
    ready_mode = 1;
    cycles(10);
    check("t5_level_after", level, 0);

    // Select changes mid-burst only take effect at the next IDLE
    mode = 1'b0; sel = 3'd7;
    push_words(4, 5);
    cycles(5);
    check("t6_no_grant_state", state, 0);
    check("t6_no_grant_valid", out_valid, 0);
    check("t6_ch4_level", lvl_of(4), 5);
    push_words(6, 10);
    ready_mode = 0;
    cycles(1);
    model_burst(6);
    model_drain_select(4);
    sel = 3'd6;
    wait_out_valid(20);
    @(negedge clk);
    sel = 3'd4;
    ready_mode = 2;
    wait_drain(300);
    check_levels("t6_level_mid");
    sel = 3'd6;
    model_drain_select(6);
    wait_drain(100);

    // Randomised load/drain rounds
    for (int it = 0; it < 6; it++) begin
      int park;
      int s;
      park = $urandom_range(0, CHANNELS - 1);
      mode = 1'b0; sel = CW'(park); ready_mode = 2;
      cycles(2);
      load_random(park, $urandom_range(8, 25));
      check("rand_overflow", overflow, ovf_m);
      check_levels("rand_level_loaded");
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, CHANNELS - 1);
        model_drain_select(s);
        sel = CW'(s);
        wait_drain(1000);
        check_levels("rand_level_select");
      end
      mode = 1'b1;
      model_drain_rr();
      wait_drain(3000);
      check_levels("rand_level_rr");
      check("rand_overflow_kept", overflow, ovf_m);
      do_clear();
      check("rand_overflow_clr", overflow, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
